// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // Clocks from the accept edge to the busy fall for one frame.
  function automatic int unsigned frame_clocks(input int unsigned cpb, input int unsigned db,
                                               input int unsigned pe, input int unsigned sb);
    return cpb * (1 + db + pe + sb);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side handshake plus serial pin of the parametrised UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 send;
  logic                 TXD;
  logic                 td_busy;
  logic                 tx_done;

  modport master (
    output tx_data,
    output send,
    input  TXD,
    input  td_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  send,
    output TXD,
    output td_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: restart on clear or terminal count, never wraps past CntMax.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS data LSB first, optional parity, stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_param_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam bit ParMode = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  assign accept = (state_q == IDLE) && bus.send;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  // Frame sequencing; TXD is computed one edge ahead so the pin stays registered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.send) begin
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ ParMode;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastData) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              txd_d   = par_q;
              state_d = PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            txd_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          txd_d   = 1'b1;
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx_q == LastStop) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any frame in progress and over send.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.TXD     = txd_q;
  assign bus.td_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across five parameter sets sharing one clock and reset.
module tb_uart_tx_param;

  logic       clk;
  logic       reset;
  logic [4:0] send_w;
  logic [8:0] tx_word;
  logic [4:0] txd_w, busy_w, done_w;
  int         checks;
  int         failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: 4 clk/bit 8N1   b: 8E1   c: 8O1   d: 7N2   e: 1 clk/bit 8N1
  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8)) if_b ();
  uart_tx_param_if #(.DATA_BITS(8)) if_c ();
  uart_tx_param_if #(.DATA_BITS(7)) if_d ();
  uart_tx_param_if #(.DATA_BITS(8)) if_e ();

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk(clk), .reset(reset), .bus(if_c));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_d (.clk(clk), .reset(reset), .bus(if_d));
  uart_tx_param #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_e (.clk(clk), .reset(reset), .bus(if_e));

  assign if_a.send = send_w[0];
  assign if_b.send = send_w[1];
  assign if_c.send = send_w[2];
  assign if_d.send = send_w[3];
  assign if_e.send = send_w[4];
  assign if_a.tx_data = tx_word[7:0];
  assign if_b.tx_data = tx_word[7:0];
  assign if_c.tx_data = tx_word[7:0];
  assign if_d.tx_data = tx_word[6:0];
  assign if_e.tx_data = tx_word[7:0];
  assign txd_w  = {if_e.TXD, if_d.TXD, if_c.TXD, if_b.TXD, if_a.TXD};
  assign busy_w = {if_e.td_busy, if_d.td_busy, if_c.td_busy, if_b.td_busy, if_a.td_busy};
  assign done_w = {if_e.tx_done, if_d.tx_done, if_c.tx_done, if_b.tx_done, if_a.tx_done};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Sends one word on DUT d and checks the per-clock TXD waveform, busy length and done pulse.
  // bits[i] is the i-th serial bit; hold_at >= 0 re-raises send with 0x00 at that clock.
  task automatic run_frame(input int d, input int cpb, input int nbits, input logic [15:0] bits,
                           input logic [8:0] word, input int hold_at, input string tag);
    logic [63:0] obs, exp;
    int f, busy_n, done_n, done_at, idle_n;
    logic busy_last;
    f = cpb * nbits;
    obs = '0;
    exp = '0;
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    busy_last = 1'b0;
    @(negedge clk);
    tx_word = word;
    send_w[d] = 1'b1;
    @(posedge clk);
    #1;
    send_w[d] = 1'b0;
    for (int k = 0; k <= f + 1; k++) begin
      @(negedge clk);
      obs[k] = txd_w[d];
      exp[k] = (k < f) ? bits[k / cpb] : !(hold_at >= 0 && k == f + 1);
      if (k <= f && busy_w[d]) busy_n++;
      if (done_w[d]) begin
        done_n++;
        done_at = k;
      end
      busy_last = busy_w[d];
      if (k == hold_at) begin
        tx_word = 9'h000;
        send_w[d] = 1'b1;
      end
    end
    check({tag, "_txd"}, obs, exp);
    check({tag, "_busy_len"}, 64'(busy_n), 64'(f));
    check({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    check({tag, "_done_at"}, 64'(done_at), 64'(f));
    if (hold_at >= 0) begin
      check({tag, "_rearm_busy"}, 64'(busy_last), 64'd1);
    end
    send_w[d] = 1'b0;
    idle_n = 0;
    while (busy_w[d] && idle_n < 200) begin
      @(negedge clk);
      idle_n++;
    end
    check({tag, "_idle"}, 64'(busy_w[d]), 64'd0);
  endtask

  initial begin
    int done_n;
    int busy_n;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    send_w = '0;
    tx_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 64'(txd_w), 64'h1f);
    check("rst_busy", 64'(busy_w), 64'h0);
    check("rst_done", 64'(done_w), 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 4, 10, 16'b0000_0011_0100_1010, 9'h0A5, -1, "a5_8n1");
    // 0xA5 even parity -> 0, odd parity -> 1
    run_frame(1, 4, 11, 16'b0000_0101_0100_1010, 9'h0A5, -1, "a5_8e1");
    run_frame(2, 4, 11, 16'b0000_0111_0100_1010, 9'h0A5, -1, "a5_8o1");
    // 0x7F 7N2: start low, nine high bits
    run_frame(3, 4, 10, 16'b0000_0011_1111_1110, 9'h07F, -1, "7f_7n2");
    // 0x01 at one clock per bit
    run_frame(4, 1, 10, 16'b0000_0010_0000_0010, 9'h001, -1, "01_cpb1");
    // send with 0x00 at clock 10 is ignored; held send restarts right after tx_done
    run_frame(0, 4, 10, 16'b0000_0011_0100_1010, 9'h0A5, 10, "busy_ignore");

    // Reset in the middle of a frame
    @(negedge clk);
    tx_word = 9'h0A5;
    send_w[0] = 1'b1;
    @(posedge clk);
    #1;
    send_w[0] = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", 64'(txd_w[0]), 64'd1);
    check("rst_mid_busy", 64'(busy_w[0]), 64'd0);
    check("rst_mid_done", 64'(done_w[0]), 64'd0);
    reset = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_w[0]) done_n++;
      if (busy_w[0]) busy_n++;
    end
    check("rst_mid_no_done", 64'(done_n), 64'd0);
    check("rst_mid_no_busy", 64'(busy_n), 64'd0);

    // Reset and send on the same edge: reset wins
    reset = 1'b1;
    send_w[0] = 1'b1;
    @(negedge clk);
    check("rst_send_busy", 64'(busy_w[0]), 64'd0);
    check("rst_send_txd", 64'(txd_w[0]), 64'd1);
    reset = 1'b0;
    send_w[0] = 1'b0;
    @(negedge clk);
    check("rst_send_after", 64'(busy_w[0]), 64'd0);

    // Fresh frame after reset: 0x3C -> 0,0,0,1,1,1,1,0,0,1
    run_frame(0, 4, 10, 16'b0000_0010_0111_1000, 9'h03C, -1, "3c_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and successor to the fixed 8-bit, one-bit-per-clock transmitter. It serialises a parallel word onto TXD as a standard asynchronous frame: start bit, DATA_BITS data bits LSB first, an optional parity bit, then 1 or 2 stop bits. Each bit is held for CLKS_PER_BIT clocks by an internal baud counter. It sits between the host-side send/busy handshake and the serial pin, and pairs with the receiver.

Parameters:
CLKS_PER_BIT, 16, clocks per serial bit; legal range >= 1.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, used only when PARITY_EN=1; 0 selects even parity, 1 selects odd parity.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
tx_data  input  DATA_BITS  word to send; sampled only on the accept cycle.
send  input  1  request; accepted on a posedge where td_busy=0 and reset=0.
TXD  output  1  serial line, registered, idles high.
td_busy  output  1  high while a frame is in progress.
tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: at the reset edge, state<=IDLE, TXD<=1, td_busy<=0, tx_done<=0, baud counter<=0 and bit index<=0. Reset overrides every state, including mid-frame, and takes priority over send.
- States are IDLE, START, DATA, PARITY and STOP.
  - PARITY is skipped when PARITY_EN=0.
  - STOP spans STOP_BITS bit periods.
- IDLE:
  - TXD=1 and td_busy=0.
  - On send=1 at a posedge: latch tx_data into a shift register; if PARITY_EN=1, compute the parity bit as XOR of the latched word, XORed with PARITY_ODD.
  - On that same edge: TXD<=0, td_busy<=1, state<=START, baud counter<=0.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - At terminal count it resets to 0 and the FSM advances one bit.
  - Every bit, including each stop bit, is therefore exactly CLKS_PER_BIT clocks on TXD.
- START: hold TXD=0 for one bit, then state<=DATA and drive TXD from shift[0].
- DATA:
  - Shift right once per bit period.
  - After DATA_BITS bits, move to PARITY (TXD<=parity bit) when PARITY_EN=1, otherwise to STOP (TXD<=1).
- PARITY: one bit period, then state<=STOP with TXD<=1.
- STOP:
  - TXD=1 for STOP_BITS bit periods.
  - On the final terminal count: state<=IDLE, td_busy<=0, tx_done<=1 for exactly one cycle.
- Frame length from the accept edge to the td_busy fall is CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) clocks.
- Handshake:
  - send is ignored while td_busy=1; there is no queueing.
  - tx_data may change freely after the accept edge.
  - Back-to-back: send held high is re-accepted on the first edge with td_busy=0, i.e. the cycle tx_done is high. That gives a zero-gap next start bit, while the line still shows full stop bits.
- Simultaneous reset and send: reset wins and the frame is not started.
- Counter widths:
  - Baud counter uses $clog2(CLKS_PER_BIT) bits, minimum 1.
  - Bit index uses $clog2(DATA_BITS+1) bits.
  - No wrap occurs beyond the terminal counts.
- CLKS_PER_BIT=1 degenerates to one bit per clock and must work.

Decomposition:
- Shared package uart_pkg:
  - State enum tx_state_t with values IDLE, START, DATA, PARITY and STOP.
  - Parity-mode constants PAR_EVEN=0 and PAR_ODD=1.
  - A function frame_clocks(cpb, db, pe, sb).
- One sub-module, uart_baud_tick: parametrised by CLKS_PER_BIT, with inputs clk, reset and clear, and output tick.
  - clear zeroes the count; the FSM asserts it on the accept edge.
  - tick pulses on terminal count.
  - The receiver reuses it.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY_EN=0, send with tx_data=0xA5 -> TXD bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks; td_busy high for 40 clocks; a single tx_done pulse.
2. PARITY_EN=1, PARITY_ODD=0, tx_data=0xA5 -> parity bit 0; frame 44 clocks. Repeat with PARITY_ODD=1 -> parity bit 1.
3. STOP_BITS=2, DATA_BITS=7, tx_data=0x7F, CLKS_PER_BIT=4 -> TXD low 4 clocks, high 36 clocks; td_busy 40 clocks.
4. Assert send again with tx_data=0x00 at clock 10 of a busy frame -> ignored, original frame unchanged. Hold send through tx_done -> second start bit begins the edge after td_busy falls.
5. Pulse reset at clock 17 of a frame -> next edge TXD=1, td_busy=0, no tx_done. A fresh send afterwards yields a full correct frame.
6. CLKS_PER_BIT=1, tx_data=0x01, 8N1 -> TXD 0,1,0,0,0,0,0,0,0,1 on consecutive clocks; td_busy high for 10 clocks.
